// File: rtl/exec_mem_latch.sv
// Execute-to-memory pipeline register: branch resolve, jal link, overflow rewrite.
// Optional saturating exception counter enabled by EXEC_EXC_COUNT_EN.
module exec_mem_latch #(
    parameter int EXC_REG  = 30,
    parameter int LINK_REG = 31
`ifdef EXEC_EXC_COUNT_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_opcode,
    input  logic [4:0]  in_aluop,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_alu_result,
    input  logic        in_isNotEqual,
    input  logic        in_isLessThan,
    input  logic        in_overflow,
    input  logic [31:0] in_store_data,
    input  logic [31:0] in_target,
    input  logic        ctrl_stall,
    input  logic        ctrl_flush,
    output logic        out_valid,
    output logic [4:0]  out_opcode,
    output logic [4:0]  out_rd,
    output logic [31:0] out_result,
    output logic [31:0] out_store_data,
    output logic        out_we,
    output logic        out_exc,
    output logic        branch_taken,
    output logic [31:0] branch_target
`ifdef EXEC_EXC_COUNT_EN
    ,
    output logic [CNT_W-1:0] exc_count
`endif
);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;

    logic        valid_q, valid_d;
    logic [4:0]  opcode_q, opcode_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] result_q, result_d;
    logic [31:0] store_q, store_d;
    logic        we_q, we_d;
    logic        exc_q, exc_d;
    logic        take_q, take_d;
    logic [31:0] target_q, target_d;
    logic        issued_q, issued_d;

    logic [4:0]  ld_rd;
    logic [31:0] ld_result;
    logic [31:0] ld_store;
    logic        ld_we;
    logic        ld_exc;
    logic        ld_take;
    logic [31:0] ld_target;
    logic        bubble;
    logic        load_en;

    always_comb begin
        ld_rd     = in_rd;
        ld_result = in_alu_result;
        ld_store  = '0;
        ld_we     = 1'b0;
        ld_exc    = 1'b0;
        ld_take   = 1'b0;
        ld_target = '0;
        case (in_opcode)
            OP_R, OP_ADDI, OP_LW: ld_we = 1'b1;
            OP_SW: ld_store = in_store_data;
            OP_BNE: begin
                ld_take   = in_isNotEqual;
                ld_target = in_target;
            end
            OP_BLT: begin
                ld_take   = in_isLessThan;
                ld_target = in_target;
            end
            OP_JAL: begin
                ld_result = in_pc + 32'd1;
                ld_rd     = 5'(LINK_REG);
                ld_we     = 1'b1;
            end
            OP_SETX: begin
                ld_result = in_target;
                ld_rd     = 5'(EXC_REG);
                ld_we     = 1'b1;
            end
            default: ld_we = 1'b0;
        endcase
        // Arithmetic overflow is reported through rstatus with a cause code.
        if (in_overflow) begin
            if (in_opcode == OP_R && in_aluop == ALU_ADD) begin
                ld_rd     = 5'(EXC_REG);
                ld_result = 32'd1;
                ld_exc    = 1'b1;
            end else if (in_opcode == OP_R && in_aluop == ALU_SUB) begin
                ld_rd     = 5'(EXC_REG);
                ld_result = 32'd3;
                ld_exc    = 1'b1;
            end else if (in_opcode == OP_ADDI) begin
                ld_rd     = 5'(EXC_REG);
                ld_result = 32'd2;
                ld_exc    = 1'b1;
            end
        end
    end

    assign bubble  = ctrl_flush | (~ctrl_stall & ~in_valid);
    assign load_en = ~ctrl_flush & ~ctrl_stall & in_valid;

    always_comb begin
        valid_d  = valid_q;
        opcode_d = opcode_q;
        rd_d     = rd_q;
        result_d = result_q;
        store_d  = store_q;
        we_d     = we_q;
        exc_d    = exc_q;
        take_d   = take_q;
        target_d = target_q;
        // While stalled, a pulse already shown must not repeat.
        issued_d = issued_q | take_q;
        if (bubble) begin
            valid_d  = 1'b0;
            opcode_d = '0;
            rd_d     = '0;
            result_d = '0;
            store_d  = '0;
            we_d     = 1'b0;
            exc_d    = 1'b0;
            take_d   = 1'b0;
            target_d = '0;
            issued_d = 1'b0;
        end else if (load_en) begin
            valid_d  = 1'b1;
            opcode_d = in_opcode;
            rd_d     = ld_rd;
            result_d = ld_result;
            store_d  = ld_store;
            we_d     = ld_we;
            exc_d    = ld_exc;
            take_d   = ld_take;
            target_d = ld_target;
            issued_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= 1'b0;
            opcode_q <= '0;
            rd_q     <= '0;
            result_q <= '0;
            store_q  <= '0;
            we_q     <= 1'b0;
            exc_q    <= 1'b0;
            take_q   <= 1'b0;
            target_q <= '0;
            issued_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            store_q  <= store_d;
            we_q     <= we_d;
            exc_q    <= exc_d;
            take_q   <= take_d;
            target_q <= target_d;
            issued_q <= issued_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_opcode     = opcode_q;
    assign out_rd         = rd_q;
    assign out_result     = result_q;
    assign out_store_data = store_q;
    assign out_we         = we_q;
    assign out_exc        = exc_q;
    assign branch_taken   = take_q & ~issued_q;
    assign branch_target  = target_q;

`ifdef EXEC_EXC_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_en && ld_exc && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign exc_count = cnt_q;
`endif

endmodule

// File: tb/tb_exec_mem_latch.sv
// Self-checking bench for exec_mem_latch: vector table plus stall/flush/reset sequences.
// Define EXEC_EXC_COUNT_EN to also exercise the exception counter.
module tb_exec_mem_latch;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_OTH  = 5'b01111;

    typedef struct packed {
        logic        valid;
        logic [4:0]  op;
        logic [4:0]  aluop;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        ne;
        logic        lt;
        logic        ovf;
        logic [31:0] sd;
        logic [31:0] tgt;
        logic [31:0] pc;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] sd;
        logic        we;
        logic        exc;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [4:0]  in_opcode;
    logic [4:0]  in_aluop;
    logic [4:0]  in_rd;
    logic [31:0] in_alu_result;
    logic        in_isNotEqual;
    logic        in_isLessThan;
    logic        in_overflow;
    logic [31:0] in_store_data;
    logic [31:0] in_target;
    logic        ctrl_stall;
    logic        ctrl_flush;
    logic        out_valid;
    logic [4:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic        out_we;
    logic        out_exc;
    logic        branch_taken;
    logic [31:0] branch_target;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

`ifdef EXEC_EXC_COUNT_EN
    logic [3:0] exc_count;
    exec_mem_latch #(.CNT_W(4)) dut (
`else
    exec_mem_latch dut (
`endif
        .clock(clock), .reset(reset), .in_valid(in_valid),
        .in_pc(in_pc), .in_opcode(in_opcode), .in_aluop(in_aluop),
        .in_rd(in_rd), .in_alu_result(in_alu_result),
        .in_isNotEqual(in_isNotEqual), .in_isLessThan(in_isLessThan),
        .in_overflow(in_overflow), .in_store_data(in_store_data),
        .in_target(in_target), .ctrl_stall(ctrl_stall),
        .ctrl_flush(ctrl_flush), .out_valid(out_valid),
        .out_opcode(out_opcode), .out_rd(out_rd),
        .out_result(out_result), .out_store_data(out_store_data),
        .out_we(out_we), .out_exc(out_exc),
        .branch_taken(branch_taken), .branch_target(branch_target)
`ifdef EXEC_EXC_COUNT_EN
        , .exc_count(exc_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h required=0x%08h",
                     name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, ".valid"}, 32'(out_valid), 32'(e.valid));
        chk({tag, ".opcode"}, 32'(out_opcode), 32'(e.op));
        chk({tag, ".rd"}, 32'(out_rd), 32'(e.rd));
        chk({tag, ".result"}, out_result, e.res);
        chk({tag, ".store"}, out_store_data, e.sd);
        chk({tag, ".we"}, 32'(out_we), 32'(e.we));
        chk({tag, ".exc"}, 32'(out_exc), 32'(e.exc));
        chk({tag, ".taken"}, 32'(branch_taken), 32'(e.taken));
        chk({tag, ".target"}, branch_target, e.tgt);
    endtask

    task automatic drive(input in_t i);
        in_valid      = i.valid;
        in_opcode     = i.op;
        in_aluop      = i.aluop;
        in_rd         = i.rd;
        in_alu_result = i.res;
        in_isNotEqual = i.ne;
        in_isLessThan = i.lt;
        in_overflow   = i.ovf;
        in_store_data = i.sd;
        in_target     = i.tgt;
        in_pc         = i.pc;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic in_t add_in(input logic ovf, input logic [4:0] rd,
                                   input logic [31:0] res);
        return '{1'b1, OP_R, 5'd0, rd, res, 1'b0, 1'b0, ovf,
                 32'd0, 32'd0, 32'd0};
    endfunction

    localparam exp_t ZERO = '0;
    localparam int NV = 16;
    vec_t v [NV];

    initial begin
        v[0]  = '{'{1, OP_R, 5'd0, 5'd5, 32'h7, 0, 0, 0, 0, 0, 0},
                  '{1, OP_R, 5'd5, 32'h7, 0, 1, 0, 0, 0}};
        v[1]  = '{'{1, OP_R, 5'd0, 5'd5, 32'h7, 0, 0, 1, 0, 0, 0},
                  '{1, OP_R, 5'd30, 32'h1, 0, 1, 1, 0, 0}};
        v[2]  = '{'{1, OP_R, 5'd1, 5'd6, 32'h9, 0, 0, 1, 0, 0, 0},
                  '{1, OP_R, 5'd30, 32'h3, 0, 1, 1, 0, 0}};
        v[3]  = '{'{1, OP_ADDI, 5'd0, 5'd7, 32'h9, 0, 0, 1, 0, 0, 0},
                  '{1, OP_ADDI, 5'd30, 32'h2, 0, 1, 1, 0, 0}};
        v[4]  = '{'{1, OP_ADDI, 5'd3, 5'd7, 32'h55, 0, 0, 0, 0, 0, 0},
                  '{1, OP_ADDI, 5'd7, 32'h55, 0, 1, 0, 0, 0}};
        v[5]  = '{'{1, OP_LW, 5'd0, 5'd8, 32'h100, 0, 0, 0, 0, 0, 0},
                  '{1, OP_LW, 5'd8, 32'h100, 0, 1, 0, 0, 0}};
        v[6]  = '{'{1, OP_SW, 5'd0, 5'd9, 32'h200, 0, 0, 0,
                    32'hDEAD, 0, 0},
                  '{1, OP_SW, 5'd9, 32'h200, 32'hDEAD, 0, 0, 0, 0}};
        v[7]  = '{'{1, OP_JAL, 5'd0, 5'd3, 32'h77, 0, 0, 0, 0, 0,
                    32'hFFFF_FFFF},
                  '{1, OP_JAL, 5'd31, 32'h0, 0, 1, 0, 0, 0}};
        v[8]  = '{'{1, OP_SETX, 5'd0, 5'd4, 32'h77, 0, 0, 0, 0,
                    32'h1234, 0},
                  '{1, OP_SETX, 5'd30, 32'h1234, 0, 1, 0, 0, 0}};
        v[9]  = '{'{1, OP_BLT, 5'd0, 5'd1, 32'h0, 1, 0, 0, 0,
                    32'h80, 0},
                  '{1, OP_BLT, 5'd1, 32'h0, 0, 0, 0, 0, 32'h80}};
        v[10] = '{'{1, OP_OTH, 5'd0, 5'd2, 32'h33, 0, 0, 1, 0, 0, 0},
                  '{1, OP_OTH, 5'd2, 32'h33, 0, 0, 0, 0, 0}};
        v[11] = '{'{1, OP_R, 5'd2, 5'd2, 32'h44, 0, 0, 1, 0, 0, 0},
                  '{1, OP_R, 5'd2, 32'h44, 0, 1, 0, 0, 0}};
        v[12] = '{'{0, OP_R, 5'd0, 5'd5, 32'h99, 1, 1, 1, 5, 5, 5},
                  ZERO};
        v[13] = '{'{1, OP_BNE, 5'd0, 5'd0, 32'h0, 1, 0, 0, 0,
                    32'h40, 0},
                  '{1, OP_BNE, 5'd0, 32'h0, 0, 0, 0, 1, 32'h40}};
        v[14] = '{'{1, OP_R, 5'd0, 5'd0, 32'h5, 0, 0, 0, 0, 0, 0},
                  '{1, OP_R, 5'd0, 32'h5, 0, 1, 0, 0, 0}};
        v[15] = '{'{1, OP_BLT, 5'd0, 5'd0, 32'h0, 0, 1, 0, 0,
                    32'h90, 0},
                  '{1, OP_BLT, 5'd0, 32'h0, 0, 0, 0, 1, 32'h90}};

        reset = 1'b1;
        ctrl_stall = 1'b0;
        ctrl_flush = 1'b0;
        drive('0);
        repeat (2) tick();
        chk_out("reset", ZERO);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out("idle", ZERO);
        end

        for (int k = 0; k < NV; k++) begin
            drive(v[k].i);
            tick();
            chk_out($sformatf("vec%0d", k), v[k].e);
        end

        drive('{1, OP_BNE, 5'd0, 5'd3, 32'h0, 1, 0, 0, 0, 32'h40, 0});
        tick();
        chk_out("bne_load",
                '{1, OP_BNE, 5'd3, 32'h0, 0, 0, 0, 1, 32'h40});
        ctrl_stall = 1'b1;
        drive(add_in(1'b0, 5'd9, 32'hABCD));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out($sformatf("bne_stall%0d", k),
                    '{1, OP_BNE, 5'd3, 32'h0, 0, 0, 0, 0, 32'h40});
        end
        ctrl_stall = 1'b0;
        drive('0);
        tick();
        chk_out("bne_after", ZERO);

        drive(add_in(1'b0, 5'd12, 32'hC0DE));
        tick();
        chk_out("pre_flush", '{1, OP_R, 5'd12, 32'hC0DE, 0, 1, 0, 0, 0});
        ctrl_stall = 1'b1;
        ctrl_flush = 1'b1;
        drive('{1, OP_ADDI, 5'd0, 5'd4, 32'h11, 0, 0, 0, 0, 0, 0});
        tick();
        chk_out("flush_stall", ZERO);
        ctrl_flush = 1'b0;
        ctrl_stall = 1'b0;

        drive(add_in(1'b1, 5'd5, 32'h1));
        tick();
        ctrl_stall = 1'b1;
        reset = 1'b1;
        tick();
        chk_out("reset_stall", ZERO);
        reset = 1'b0;
        ctrl_stall = 1'b0;

`ifdef EXEC_EXC_COUNT_EN
        drive('0);
        tick();
        chk("cnt_reset", 32'(exc_count), 32'd0);
        drive(add_in(1'b1, 5'd5, 32'h1));
        tick();
        ctrl_flush = 1'b1;
        tick();
        ctrl_flush = 1'b0;
        tick();
        chk("cnt_two", 32'(exc_count), 32'd2);
        ctrl_stall = 1'b1;
        tick();
        chk("cnt_stall", 32'(exc_count), 32'd2);
        ctrl_stall = 1'b0;
        drive(add_in(1'b0, 5'd5, 32'h1));
        tick();
        chk("cnt_noovf", 32'(exc_count), 32'd2);
        drive(add_in(1'b1, 5'd5, 32'h1));
        repeat (20) tick();
        chk("cnt_sat", 32'(exc_count), 32'hF);
        reset = 1'b1;
        tick();
        chk("cnt_clear", 32'(exc_count), 32'd0);
        reset = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
